// File: rtl/debug_pkg.sv
// Shared definitions for the debug/loader front-end: FSM state encoding,
// UART command bytes and the instruction that terminates a program load.
package debug_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_WRITE  = 3'd2,
        ST_READY  = 3'd3,
        ST_RUN    = 3'd4,
        ST_STEP   = 3'd5,
        ST_REPORT = 3'd6
    } state_t;

    localparam logic [7:0]  CMD_LOAD   = 8'h4C;   // 'L'
    localparam logic [7:0]  CMD_RUN    = 8'h52;   // 'R'
    localparam logic [7:0]  CMD_STEP   = 8'h53;   // 'S'
    localparam logic [31:0] HALT_INSTR = 32'h0000_003F;

endpackage

// File: rtl/word_serializer.sv
// Sends a wide word out over a byte-wide transmitter, most significant byte
// first. Each byte gets a one-cycle start pulse; the following byte is
// launched the cycle after the transmitter reports the previous one done.
module word_serializer #(
    parameter int BYTE_SZ = 8,
    parameter int NBYTES  = 8
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_start,
    input  logic [BYTE_SZ*NBYTES-1:0] i_word,
    input  logic                      i_tx_done,
    output logic [BYTE_SZ-1:0]        o_tx_data,
    output logic                      o_tx_start,
    output logic                      o_done
);

    localparam int W     = BYTE_SZ * NBYTES;
    localparam int IDX_W = $clog2(NBYTES);

    logic [W-1:0]     data_q, data_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             start_q, start_d;
    logic             last_byte;

    assign last_byte  = (idx_q == IDX_W'(NBYTES - 1));
    assign o_tx_data  = data_q[W-1 -: BYTE_SZ];
    assign o_tx_start = start_q;
    assign o_done     = busy_q & i_tx_done & last_byte;

    // Capture the word on start, then shift one byte per transmitter completion.
    always_comb begin
        data_d  = data_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        start_d = 1'b0;
        if (i_start) begin
            data_d  = i_word;
            idx_d   = '0;
            busy_d  = 1'b1;
            start_d = 1'b1;
        end else if (busy_q && i_tx_done) begin
            if (last_byte) begin
                busy_d = 1'b0;
            end else begin
                data_d  = data_q << BYTE_SZ;
                idx_d   = idx_q + 1'b1;
                start_d = 1'b1;
            end
        end
    end

    // Serializer state registers.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            data_q  <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            start_q <= start_d;
        end
    end

endmodule

// File: rtl/debug_loader.sv
// Debug/loader front-end for the pipeline: assembles UART bytes into
// instructions, writes them into instruction memory, gates the pipeline
// enable for run/single-step, and reports PC and data back over UART.
// Optional feature macro: DEBUG_LOADER_STEP_EN (enables the 'S' step command).
module debug_loader
    import debug_pkg::*;
#(
    parameter int INST_SZ = 32,
    parameter int PC_SZ   = 32,
    parameter int BYTE_SZ = 8,
    parameter int MEM_SZ  = 10
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [BYTE_SZ-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic               i_tx_done,
    input  logic               i_halt,
    input  logic [PC_SZ-1:0]   i_pc,
    input  logic [INST_SZ-1:0] i_data,
    output logic [INST_SZ-1:0] o_instruction,
    output logic               o_write,
    output logic               o_enable,
    output logic [BYTE_SZ-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_overflow,
    output logic               o_busy
);

    localparam int NBYTES = (PC_SZ + INST_SZ) / BYTE_SZ;

    state_t             state_q, state_d;
    logic [MEM_SZ:0]    cnt_q, cnt_d, cnt_inc;
    logic [1:0]         bidx_q, bidx_d;
    logic [INST_SZ-1:0] shift_q, shift_d;
    logic               ovf_q, ovf_d;
    logic               halted_q, halted_d;
    logic               ser_start;
    logic               ser_done;

    assign cnt_inc       = cnt_q + 1'b1;
    assign o_instruction = shift_q;
    assign o_write       = (state_q == ST_WRITE);
    assign o_enable      = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign o_busy        = !((state_q == ST_IDLE) || (state_q == ST_READY));
    assign o_overflow    = ovf_q;

    // Command decode, word assembly and run/step/report sequencing.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bidx_d    = bidx_q;
        shift_d   = shift_q;
        ovf_d     = ovf_q;
        halted_d  = halted_q;
        ser_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_rx_done && i_rx_data == CMD_LOAD) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                    bidx_d  = '0;
                    ovf_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (i_rx_done) begin
                    shift_d = {shift_q[INST_SZ-BYTE_SZ-1:0], i_rx_data};
                    bidx_d  = bidx_q + 1'b1;
                    if (bidx_q == 2'd3) state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                cnt_d = cnt_inc;
                if (shift_q == INST_SZ'(HALT_INSTR)) begin
                    state_d = ST_READY;
                end else if (cnt_inc[MEM_SZ]) begin
                    // Memory full: stop accepting words until the next load.
                    ovf_d   = 1'b1;
                    state_d = ST_READY;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_READY: begin
                if (i_rx_done) begin
                    if (i_rx_data == CMD_LOAD) begin
                        state_d = ST_LOAD;
                        cnt_d   = '0;
                        bidx_d  = '0;
                        ovf_d   = 1'b0;
                    end else if (i_rx_data == CMD_RUN) begin
                        state_d  = ST_RUN;
                        halted_d = 1'b0;
                    end
`ifdef DEBUG_LOADER_STEP_EN
                    else if (i_rx_data == CMD_STEP) begin
                        state_d  = ST_STEP;
                        halted_d = 1'b0;
                    end
`endif
                end
            end
            ST_RUN: begin
                if (i_halt) begin
                    halted_d  = 1'b1;
                    ser_start = 1'b1;
                    state_d   = ST_REPORT;
                end
            end
`ifdef DEBUG_LOADER_STEP_EN
            ST_STEP: begin
                // A halt that coincides with the step ends the session after reporting.
                halted_d  = i_halt;
                ser_start = 1'b1;
                state_d   = ST_REPORT;
            end
`endif
            ST_REPORT: begin
                if (ser_done) state_d = halted_q ? ST_IDLE : ST_READY;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and datapath registers.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            bidx_q   <= '0;
            shift_q  <= '0;
            ovf_q    <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bidx_q   <= bidx_d;
            shift_q  <= shift_d;
            ovf_q    <= ovf_d;
            halted_q <= halted_d;
        end
    end

    word_serializer #(
        .BYTE_SZ (BYTE_SZ),
        .NBYTES  (NBYTES)
    ) u_ser (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_start    (ser_start),
        .i_word     ({i_pc, i_data}),
        .i_tx_done  (i_tx_done),
        .o_tx_data  (o_tx_data),
        .o_tx_start (o_tx_start),
        .o_done     (ser_done)
    );

endmodule

// File: tb/tb_debug_loader.sv
// Directed testbench for debug_loader: load, reload after reset, run/halt
// reporting, optional single-step, overflow and ignored-input cases.
module tb_debug_loader;
    import debug_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        tx_done;
    logic        halt;
    logic [31:0] pc;
    logic [31:0] data;
    logic [31:0] instruction;
    logic        wr, en, tx_start, ovf, busy;
    logic [7:0]  tx_data;

    int n_checks = 0;
    int n_errors = 0;
    int wr_cnt = 0;
    int en_cnt = 0;
    logic [31:0] wr_q[$];
    logic [7:0]  tx_q[$];

    always #5 clk = ~clk;

    debug_loader dut (
        .i_clk         (clk),
        .i_reset       (rst_n),
        .i_rx_data     (rx_data),
        .i_rx_done     (rx_done),
        .i_tx_done     (tx_done),
        .i_halt        (halt),
        .i_pc          (pc),
        .i_data        (data),
        .o_instruction (instruction),
        .o_write       (wr),
        .o_enable      (en),
        .o_tx_data     (tx_data),
        .o_tx_start    (tx_start),
        .o_overflow    (ovf),
        .o_busy        (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] get_wr(input int i);
        return (i < wr_q.size()) ? wr_q[i] : 32'hxxxx_xxxx;
    endfunction

    function automatic logic [7:0] get_tx(input int i);
        return (i < tx_q.size()) ? tx_q[i] : 8'hxx;
    endfunction

    task automatic clear_mon();
        wr_cnt = 0;
        en_cnt = 0;
        wr_q.delete();
        tx_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk); #1;
        rx_done = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        rx_done = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, 64'(n < 2000), 64'd1);
    endtask

    task automatic chk_tx(input string tag, input logic [63:0] exp);
        chk({tag, "_count"}, 64'(tx_q.size()), 64'd8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("%s_byte%0d", tag, i), 64'(get_tx(i)), 64'(exp[63-8*i -: 8]));
    endtask

    // Output monitor: record write pulses and count enable cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (wr === 1'b1) begin
                wr_cnt++;
                wr_q.push_back(instruction);
            end
            if (en === 1'b1) en_cnt++;
        end
    end

    // Transmitter model: capture each started byte, report done two cycles later.
    initial begin
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                tx_q.push_back(tx_data);
                repeat (2) @(posedge clk);
                #1 tx_done = 1'b1;
                @(posedge clk);
                #1 tx_done = 1'b0;
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        rx_data = 8'h00;
        rx_done = 1'b0;
        halt    = 1'b0;
        pc      = 32'h0;
        data    = 32'h0;

        // Reset state
        repeat (2) @(posedge clk); #1;
        chk("rst_write",  64'(wr), 64'd0);
        chk("rst_enable", 64'(en), 64'd0);
        chk("rst_txstart", 64'(tx_start), 64'd0);
        chk("rst_txdata", 64'(tx_data), 64'd0);
        chk("rst_ovf",    64'(ovf), 64'd0);
        chk("rst_busy",   64'(busy), 64'd0);
        chk("rst_instr",  64'(instruction), 64'd0);
        rst_n = 1'b1;

        // Reset after two bytes of a word, then a full reload
        send_byte(CMD_LOAD);
        send_byte(8'hAA);
        send_byte(8'hBB);
        chk("midload_busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midload_async_instr", 64'(instruction), 64'd0);
        chk("midload_async_busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_mon();
        send_byte(CMD_LOAD);
        send_word(32'hDEAD_BEEF);
        chk("reload_write_now", 64'(wr), 64'd1);
        @(posedge clk); #1;
        chk("reload_write_gone", 64'(wr), 64'd0);
        repeat (3) @(posedge clk); #1;
        chk("reload_count", 64'(wr_cnt), 64'd1);
        chk("reload_word", 64'(get_wr(0)), 64'hDEAD_BEEF);

        // Three-word program ending in HALT
        do_reset();
        clear_mon();
        send_byte(CMD_LOAD);
        send_word(32'hAC03_0005);
        send_word(32'h8C03_0005);
        send_word(32'h0000_003F);
        repeat (3) @(posedge clk); #1;
        chk("load_count", 64'(wr_cnt), 64'd3);
        chk("load_w0", 64'(get_wr(0)), 64'hAC03_0005);
        chk("load_w1", 64'(get_wr(1)), 64'h8C03_0005);
        chk("load_w2", 64'(get_wr(2)), 64'h0000_003F);
        chk("load_state", 64'(dut.state_q), 64'(ST_READY));
        chk("load_ovf", 64'(ovf), 64'd0);
        chk("load_busy", 64'(busy), 64'd0);

        // Run for 20 enabled cycles, with a stray byte while running
        clear_mon();
        send_byte(CMD_RUN);
        send_byte(CMD_LOAD);
        repeat (17) @(posedge clk); #1;
        halt = 1'b1;
        pc   = 32'h0000_000C;
        data = 32'h0000_0007;
        @(posedge clk);
        @(negedge clk);
        chk("run_enable_off", 64'(en), 64'd0);
        chk("run_first_txstart", 64'(tx_start), 64'd1);
        wait_idle("run_report_timeout");
        chk("run_enable_cycles", 64'(en_cnt), 64'd20);
        chk_tx("run_tx", 64'h0000_000C_0000_0007);
        chk("run_state", 64'(dut.state_q), 64'(ST_IDLE));
        chk("run_no_write", 64'(wr_cnt), 64'd0);

        // Unknown and non-load commands in IDLE; halt during LOAD
        clear_mon();
        send_byte(8'h41);
        send_byte(CMD_RUN);
        send_byte(CMD_STEP);
        repeat (3) @(posedge clk); #1;
        chk("idle_ignore_busy", 64'(busy), 64'd0);
        chk("idle_ignore_state", 64'(dut.state_q), 64'(ST_IDLE));
        chk("idle_ignore_enable", 64'(en_cnt), 64'd0);
        chk("idle_ignore_tx", 64'(tx_q.size()), 64'd0);
        send_byte(CMD_LOAD);
        send_word(32'h1122_3344);
        repeat (2) @(posedge clk); #1;
        chk("haltload_count", 64'(wr_cnt), 64'd1);
        chk("haltload_word", 64'(get_wr(0)), 64'h1122_3344);
        chk("haltload_enable", 64'(en_cnt), 64'd0);
        chk("haltload_state", 64'(dut.state_q), 64'(ST_LOAD));
        halt = 1'b0;

        // Single step from READY
        do_reset();
        send_byte(CMD_LOAD);
        send_word(32'h0000_003F);
        repeat (2) @(posedge clk); #1;
        clear_mon();
        pc   = 32'h0000_0010;
        data = 32'h1234_5678;
        send_byte(CMD_STEP);
`ifdef DEBUG_LOADER_STEP_EN
        chk("step_enable_on", 64'(en), 64'd1);
        @(posedge clk); #1;
        chk("step_enable_off", 64'(en), 64'd0);
        chk("step_txstart", 64'(tx_start), 64'd1);
        wait_idle("step_report_timeout");
        chk("step_enable_cycles", 64'(en_cnt), 64'd1);
        chk_tx("step_tx", 64'h0000_0010_1234_5678);
        chk("step_state", 64'(dut.state_q), 64'(ST_READY));
`else
        repeat (20) @(posedge clk); #1;
        chk("nostep_enable", 64'(en_cnt), 64'd0);
        chk("nostep_tx", 64'(tx_q.size()), 64'd0);
        chk("nostep_state", 64'(dut.state_q), 64'(ST_READY));
        chk("nostep_busy", 64'(busy), 64'd0);
`endif

        // Overflow: 1025 non-HALT words, only 1024 are written
        do_reset();
        clear_mon();
        send_byte(CMD_LOAD);
        for (int i = 0; i < 1025; i++) send_word(32'h0000_0001);
        repeat (3) @(posedge clk); #1;
        chk("ovf_count", 64'(wr_cnt), 64'd1024);
        chk("ovf_last_word", 64'(get_wr(1023)), 64'h0000_0001);
        chk("ovf_flag", 64'(ovf), 64'd1);
        chk("ovf_state", 64'(dut.state_q), 64'(ST_READY));
        chk("ovf_busy", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
